// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop RX synchroniser, start-edge detect, mid-bit sampling, LSB-first assembly.
// Byte is presented one cycle after the stop sample; rdy is held until clr_rdy or the next start edge.
module uart_rx #(
  parameter int BAUD_CNT = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [11:0] LP_HALF = 12'(BAUD_CNT / 2);
  localparam logic [11:0] LP_FULL = 12'(BAUD_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_baud_cnt, w_baud_nxt;
  logic [3:0]  r_bit_cnt, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [7:0]  r_rx_data, w_rx_data_nxt;
  logic        r_rdy, w_rdy_nxt;
  logic        r_frm_err, w_frm_err_nxt;
  logic        r_rx_ff1, r_rx_sync, r_rx_prev;
  logic        w_start, w_baud_zero, w_set_rdy, w_start_clr;

  assign w_start     = r_rx_prev & ~r_rx_sync;
  assign w_baud_zero = (r_baud_cnt == 12'd0);

  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_rx_data_nxt = r_rx_data;
    w_frm_err_nxt = r_frm_err;
    w_set_rdy     = 1'b0;
    w_start_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_baud_nxt  = LP_HALF;
          w_bit_nxt   = 4'd0;
          w_start_clr = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud_cnt - 12'd1;
        end else if (r_rx_sync) begin
          // Line went back high before mid-start: treat as a glitch.
          w_state_nxt = IDLE;
        end else begin
          w_baud_nxt  = LP_FULL;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud_cnt - 12'd1;
        end else begin
          w_shift_nxt = {r_rx_sync, r_shift[7:1]};
          w_bit_nxt   = r_bit_cnt + 4'd1;
          w_baud_nxt  = LP_FULL;
          if (r_bit_cnt == 4'd7) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (!w_baud_zero) begin
          w_baud_nxt = r_baud_cnt - 12'd1;
        end else begin
          w_rx_data_nxt = r_shift;
          w_frm_err_nxt = ~r_rx_sync;
          w_set_rdy     = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // A completing frame beats a simultaneous consumer clear.
    w_rdy_nxt = r_rdy;
    if (w_set_rdy)                    w_rdy_nxt = 1'b1;
    else if (w_start_clr || clr_rdy)  w_rdy_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= 12'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rdy      <= 1'b0;
      r_frm_err  <= 1'b0;
      r_rx_ff1   <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rdy      <= w_rdy_nxt;
      r_frm_err  <= w_frm_err_nxt;
      r_rx_ff1   <= RX;
      r_rx_sync  <= r_rx_ff1;
      r_rx_prev  <= r_rx_sync;
    end
  end

  assign rx_data = r_rx_data;
  assign rdy     = r_rdy;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at BAUD_CNT=16: frames from a bit-level transmitter model,
// expected {frm_err, byte} queued at send time and popped when rdy rises.
module tb_uart_rx;

  localparam int BAUD = 16;
  localparam int FRAME = 10 * BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;

  int checks = 0;
  int failures = 0;
  logic [8:0] sb_q[$];
  logic [8:0] exp_last;
  logic       mon_prev_rdy;

  uart_rx #(.BAUD_CNT(BAUD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every rising edge of rdy must match the oldest queued frame.
  always @(negedge clk) begin
    if (rdy === 1'b1 && mon_prev_rdy !== 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rdy", 32'(rdy), 32'd0);
      end else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("sb_rx_data", 32'(rx_data), 32'(e[7:0]));
        chk("sb_frm_err", 32'(frm_err), 32'(e[8]));
      end
    end
    mon_prev_rdy <= rdy;
  end

  // Drives one frame (ncyc < FRAME aborts early). Negedge c samples state after
  // posedge c, then drives RX for the next posedge. clr_at >= 0 pulses clr_rdy
  // at that negedge; the stop sample lands on posedge 156, so clr_at=155 collides
  // with the set and clr_at=156 arrives one cycle later.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at, input int ncyc);
    int b;
    if (ncyc == FRAME) sb_q.push_back({~stop, d});
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (c == 16) chk("rdy_drop_at_start", 32'(rdy), 32'd0);
      if (c == 80) chk("rx_data_stable", 32'(rx_data), 32'(exp_last[7:0]));
      if (clr_at >= 0 && c == clr_at + 1) chk("clr_vs_set", 32'(rdy), 32'(clr_at <= 155));
      if (c == FRAME - 1) chk("rdy_at_frame_end", 32'(rdy), 32'(clr_at < 156));
      b = c / BAUD;
      if (b == 0)      RX = 1'b0;
      else if (b <= 8) RX = d[b-1];
      else             RX = stop;
      clr_rdy = (c == clr_at);
    end
    clr_rdy = 1'b0;
    if (ncyc == FRAME) exp_last = {~stop, d};
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    clr_rdy = 1'b0;
    exp_last = 9'h000;
    mon_prev_rdy = 1'b0;

    // Reset state
    idle(3);
    chk("reset_rdy", 32'(rdy), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'h00);
    chk("reset_frm_err", 32'(frm_err), 32'd0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_no_rdy", 32'(rdy), 32'd0);

    // Single frame
    send_frame(8'hA5, 1'b1, -1, FRAME);
    idle(4);
    chk("a5_data", 32'(rx_data), 32'hA5);

    // Back-to-back frames, no clear between them
    send_frame(8'h00, 1'b1, -1, FRAME);
    send_frame(8'hFF, 1'b1, -1, FRAME);
    send_frame(8'h5A, 1'b1, -1, FRAME);
    idle(4);
    chk("b2b_last_data", 32'(rx_data), 32'h5A);
    chk("b2b_sb_empty", 32'(sb_q.size()), 32'd0);

    // Clear, then a 3-cycle glitch must not start a frame
    @(negedge clk); clr_rdy = 1'b1;
    @(negedge clk); clr_rdy = 1'b0;
    @(negedge clk);
    chk("clr_rdy_clears", 32'(rdy), 32'd0);
    RX = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(40);
    chk("glitch_rdy", 32'(rdy), 32'd0);
    chk("glitch_rx_data", 32'(rx_data), 32'h5A);
    chk("glitch_frm_err", 32'(frm_err), 32'd0);

    // Bad stop bit, then a good frame clears the error
    send_frame(8'h3C, 1'b0, -1, FRAME);
    RX = 1'b1;
    idle(20);
    chk("ferr_set", 32'(frm_err), 32'd1);
    chk("ferr_data", 32'(rx_data), 32'h3C);
    chk("ferr_rdy", 32'(rdy), 32'd1);
    send_frame(8'h81, 1'b1, -1, FRAME);
    idle(4);
    chk("ferr_cleared", 32'(frm_err), 32'd0);

    // clr_rdy coincident with set, then one cycle after set
    send_frame(8'h96, 1'b1, 155, FRAME);
    idle(4);
    chk("set_wins_hold", 32'(rdy), 32'd1);
    send_frame(8'h69, 1'b1, 156, FRAME);
    idle(4);
    chk("late_clr_hold", 32'(rdy), 32'd0);
    chk("late_clr_data", 32'(rx_data), 32'h69);

    // Reset during data bit 4, then recover with a full frame
    send_frame(8'h77, 1'b1, -1, 5 * BAUD + 8);
    @(negedge clk);
    rst_n = 1'b0;
    RX = 1'b1;
    idle(2);
    rst_n = 1'b1;
    chk("midrst_rdy", 32'(rdy), 32'd0);
    chk("midrst_rx_data", 32'(rx_data), 32'h00);
    chk("midrst_frm_err", 32'(frm_err), 32'd0);
    exp_last = 9'h000;
    idle(5);
    send_frame(8'hC3, 1'b1, -1, FRAME);
    idle(4);
    chk("post_rst_data", 32'(rx_data), 32'hC3);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
